branch_ctrl: RTL and testbench

Branch/sequencing controller that drives the program counter's control interface (Start-synchronous reset, Branch, target, Done) from decoded instruction fields. Holds the PC until told to run, resolves conditional and unconditional jumps through a loadable target lookup table, halts on a halt opcode or watchdog expiry, and reports execution statistics. It sits between the instruction decoder/ALU flags and the PC block.

---
 rtl/branch_ctrl_pkg.sv | 22 ++
 rtl/branch_ctrl_lut.sv | 43 ++++
 rtl/branch_ctrl.sv | 125 ++++++++++++
 tb/tb_branch_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the branch/sequencing controller.
//   - controller state encoding
//   - default PC/target width, LUT index width and watchdog limit
//   - statistics counter width and a saturating increment helper
package branch_ctrl_pkg;

   localparam int D_DEF    = 12;
   localparam int L_DEF    = 4;
   localparam int TMAX_DEF = 4095;
   localparam int CNT_W    = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_e;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/branch_ctrl_lut.sv
// Branch target lookup table: 2^L entries of D bits.
// Ports:
//   clk        clock
//   clr        synchronous clear of every entry (highest priority)
//   we         write enable (already qualified by the caller)
//   waddr      write address
//   wdata      write data
//   raddr      read address
//   rdata      combinational read data
module branch_lut #(
   parameter int D = 12,
   parameter int L = 4
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         we,
   input  logic [L-1:0] waddr,
   input  logic [D-1:0] wdata,
   input  logic [L-1:0] raddr,
   output logic [D-1:0] rdata
);

   logic [(2**L)-1:0][D-1:0] mem_q;
   logic [(2**L)-1:0][D-1:0] mem_d;

   always_comb begin
      mem_d = mem_q;
      if (we) begin
         mem_d[waddr] = wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         mem_q <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/branch_ctrl.sv
// Branch/sequencing controller driving the PC control interface.
// Holds the PC until Go, resolves branches through a loadable target LUT,
// halts on a halt opcode or watchdog expiry, and counts executed cycles.
// Optional feature macro: BRANCH_STATS_EN (taken-branch counter; tied to 0
// when undefined).
// Ports:
//   clk, Start            clock, synchronous active-high reset
//   Go                    start execution (sampled in IDLE)
//   BrEn, BrUncond, Zero  branch decode and ALU zero flag
//   Halt                  halt opcode
//   lut_idx               LUT read index
//   lut_we/waddr/wdata    LUT write port (IDLE only)
//   Branch, target, Done  PC control outputs (combinational)
//   Timeout               sticky watchdog flag
//   instr_count           RUN cycles, saturating
//   taken_count           taken branches, saturating (stats build only)
//
// state   | meaning
// --------+----------------------------------------------
// IDLE    | PC held, LUT writable, waiting for Go
// RUN     | executing; branches resolved each cycle
// HALT    | PC held after Halt or watchdog; leave via Start
module branch_ctrl
   import branch_ctrl_pkg::*;
#(
   parameter int D    = D_DEF,
   parameter int L    = L_DEF,
   parameter int TMAX = TMAX_DEF
) (
   input  logic             clk,
   input  logic             Start,
   input  logic             Go,
   input  logic             BrEn,
   input  logic             BrUncond,
   input  logic             Zero,
   input  logic             Halt,
   input  logic [L-1:0]     lut_idx,
   input  logic             lut_we,
   input  logic [L-1:0]     lut_waddr,
   input  logic [D-1:0]     lut_wdata,
   output logic             Branch,
   output logic [D-1:0]     target,
   output logic             Done,
   output logic             Timeout,
   output logic [CNT_W-1:0] instr_count,
   output logic [CNT_W-1:0] taken_count
);

   state_e           state_q, state_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] instr_count_q, instr_count_d;
   logic [D-1:0]     lut_rdata;
   logic             in_run;
   logic             take;
   logic             wd_hit;

   assign in_run = (state_q == ST_RUN);
   assign take   = in_run & ~Halt & (BrUncond | (BrEn & Zero));
   // Watchdog fires on the TMAX-th RUN cycle, so the count reaches TMAX on HALT entry.
   assign wd_hit = in_run & ~Halt & (instr_count_q == CNT_W'(TMAX - 1));

   branch_lut #(.D(D), .L(L)) u_lut (
      .clk   (clk),
      .clr   (Start),
      .we    (lut_we & (state_q == ST_IDLE)),
      .waddr (lut_waddr),
      .wdata (lut_wdata),
      .raddr (lut_idx),
      .rdata (lut_rdata)
   );

   always_ff @(posedge clk) begin
      if (Start) begin
         state_q       <= ST_IDLE;
         timeout_q     <= 1'b0;
         instr_count_q <= '0;
      end else begin
         state_q       <= state_d;
         timeout_q     <= timeout_d;
         instr_count_q <= instr_count_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      timeout_d     = timeout_q | wd_hit;
      instr_count_d = in_run ? sat_inc(instr_count_q) : instr_count_q;
      case (state_q)
         ST_IDLE: if (Go) state_d = ST_RUN;
         ST_RUN:  if (Halt || wd_hit) state_d = ST_HALT;
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      Done   = ~in_run;
      Branch = take;
      target = take ? lut_rdata : '0;
   end

   assign Timeout     = timeout_q;
   assign instr_count = instr_count_q;

`ifdef BRANCH_STATS_EN
   logic [CNT_W-1:0] taken_count_q, taken_count_d;

   always_comb begin
      taken_count_d = take ? sat_inc(taken_count_q) : taken_count_q;
   end

   always_ff @(posedge clk) begin
      if (Start) begin
         taken_count_q <= '0;
      end else begin
         taken_count_q <= taken_count_d;
      end
   end

   assign taken_count = taken_count_q;
`else
   assign taken_count = '0;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
module tb_branch_ctrl;

   logic        clk = 1'b0;
   logic        Start, Go, BrEn, BrUncond, Zero, Halt;
   logic [3:0]  lut_idx, lut_waddr;
   logic        lut_we;
   logic [11:0] lut_wdata;
   logic        Branch, Done, Timeout;
   logic [11:0] target;
   logic [15:0] instr_count, taken_count;

   int n_checks = 0;
   int n_errors = 0;

`ifdef BRANCH_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif

   always #5 clk = ~clk;

   branch_ctrl #(.D(12), .L(4), .TMAX(8)) dut (
      .clk         (clk),
      .Start       (Start),
      .Go          (Go),
      .BrEn        (BrEn),
      .BrUncond    (BrUncond),
      .Zero        (Zero),
      .Halt        (Halt),
      .lut_idx     (lut_idx),
      .lut_we      (lut_we),
      .lut_waddr   (lut_waddr),
      .lut_wdata   (lut_wdata),
      .Branch      (Branch),
      .target      (target),
      .Done        (Done),
      .Timeout     (Timeout),
      .instr_count (instr_count),
      .taken_count (taken_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs then change 1ns after it, outputs sampled 1ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      Start = 1'b1; Go = 1'b0; BrEn = 1'b0; BrUncond = 1'b0; Zero = 1'b0;
      Halt = 1'b0; lut_idx = '0; lut_we = 1'b0; lut_waddr = '0; lut_wdata = '0;
      tick();
      Start = 1'b0;
      repeat (5) tick();
      chk("rst_done",    32'(Done), 1);
      chk("rst_branch",  32'(Branch), 0);
      chk("rst_target",  32'(target), 0);
      chk("rst_timeout", 32'(Timeout), 0);
      chk("rst_icount",  32'(instr_count), 0);
      chk("rst_tcount",  32'(taken_count), 0);

      // LUT write in IDLE; branch decode must be ignored while idle
      lut_we = 1'b1; lut_waddr = 4'd3; lut_wdata = 12'h0A5;
      tick();
      lut_we = 1'b0; BrUncond = 1'b1; lut_idx = 4'd3;
      settle();
      chk("idle_branch", 32'(Branch), 0);
      chk("idle_done",   32'(Done), 1);
      BrUncond = 1'b0;

      // Go together with a write: both take effect
      Go = 1'b1; lut_we = 1'b1; lut_waddr = 4'd5; lut_wdata = 12'h123;
      tick();
      Go = 1'b0; lut_we = 1'b0;
      settle();
      chk("run_done",   32'(Done), 0);
      chk("run_icount0", 32'(instr_count), 0);

      BrUncond = 1'b1; lut_idx = 4'd3;
      settle();
      chk("unc_branch", 32'(Branch), 1);
      chk("unc_target", 32'(target), 32'h0A5);
      tick();
      BrUncond = 1'b0; BrEn = 1'b1; Zero = 1'b0; lut_idx = 4'd5;
      settle();
      chk("tcount_1",    32'(taken_count), 32'(STATS * 1));
      chk("cnd_nz_br",   32'(Branch), 0);
      chk("cnd_nz_tgt",  32'(target), 0);
      tick();
      Zero = 1'b1;
      settle();
      chk("cnd_z_br",  32'(Branch), 1);
      chk("cnd_z_tgt", 32'(target), 32'h123);
      tick();
      BrEn = 1'b0; Zero = 1'b0;

      // Write while running must be dropped
      lut_we = 1'b1; lut_waddr = 4'd3; lut_wdata = 12'hFFF;
      tick();
      lut_we = 1'b0; BrUncond = 1'b1; lut_idx = 4'd3;
      settle();
      chk("run_we_ign", 32'(target), 32'h0A5);
      chk("icount_4",   32'(instr_count), 4);
      tick();

      // Halt beats a simultaneous jump
      Halt = 1'b1;
      settle();
      chk("halt_branch", 32'(Branch), 0);
      chk("halt_target", 32'(target), 0);
      chk("halt_done0",  32'(Done), 0);
      tick();
      Halt = 1'b0;
      settle();
      chk("halt_done",    32'(Done), 1);
      chk("halt_timeout", 32'(Timeout), 0);
      chk("halt_icount",  32'(instr_count), 6);
      chk("halt_tcount",  32'(taken_count), 32'(STATS * 3));
      chk("halt_br_ign",  32'(Branch), 0);
      BrUncond = 1'b0;
      Go = 1'b1;
      tick();
      Go = 1'b0;
      tick();
      chk("halt_go_ign", 32'(Done), 1);
      chk("halt_go_ic",  32'(instr_count), 6);

      // Watchdog with TMAX=8; Start also zeroes the LUT
      Start = 1'b1;
      tick();
      Start = 1'b0;
      settle();
      chk("wd_rst_ic", 32'(instr_count), 0);
      chk("wd_rst_tc", 32'(taken_count), 0);
      Go = 1'b1;
      tick();
      Go = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (k == 7) begin
            BrUncond = 1'b1; lut_idx = 4'd3;
            settle();
            chk("wd_last_br",  32'(Branch), 1);
            chk("wd_lut_clr",  32'(target), 0);
            chk("wd_pre_to",   32'(Timeout), 0);
         end
         settle();
         chk("wd_running", 32'(Done), 0);
         tick();
      end
      BrUncond = 1'b0;
      settle();
      chk("wd_done",    32'(Done), 1);
      chk("wd_timeout", 32'(Timeout), 1);
      chk("wd_icount",  32'(instr_count), 8);
      chk("wd_tcount",  32'(taken_count), 32'(STATS * 1));

      // Mid-run Start
      Start = 1'b1;
      tick();
      Start = 1'b0;
      settle();
      chk("mr_to_clr", 32'(Timeout), 0);
      lut_we = 1'b1; lut_waddr = 4'd2; lut_wdata = 12'h777;
      tick();
      lut_we = 1'b0; Go = 1'b1;
      tick();
      Go = 1'b0;
      tick();
      tick();
      chk("mr_icount", 32'(instr_count), 2);
      chk("mr_run",    32'(Done), 0);
      Start = 1'b1;
      tick();
      Start = 1'b0;
      settle();
      chk("mr_done",   32'(Done), 1);
      chk("mr_icount0", 32'(instr_count), 0);
      Go = 1'b1;
      tick();
      Go = 1'b0; BrUncond = 1'b1; lut_idx = 4'd2;
      settle();
      chk("mr_branch",  32'(Branch), 1);
      chk("mr_lut_clr", 32'(target), 0);
      BrUncond = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
